pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 5-bit "10101" Moore detector. It shifts a qualified serial bit stream into a WIDTH-bit history register and compares it against a runtime-programmable pattern. The match output is Moore-style and registered. Overlapping or non-overlapping detection is selectable, and an optional saturating match counter is included. It sits between the serial front end and the event/status logic of the lab designs.

---
 rtl/pattern_detector.sv | 89 ++++++++
 tb/tb_pattern_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with programmable pattern and overlap mode.
// Optional saturating match counter is built when PATDET_COUNT_EN is defined.
module pattern_detector #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             valid,
  input  logic             clear,
  input  logic             overlap,
  input  logic [WIDTH-1:0] pattern,
  output logic             out,
  output logic [WIDTH-1:0] temp,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [FW-1:0] ONE  = FW'(1);

  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_n;
  logic [WIDTH-1:0] temp_n;
  logic             out_n;
  logic             accept;
  logic             restart;

  assign accept  = valid && !clear;
  // A reported match in non-overlap mode consumes the history.
  assign restart = !overlap && out;

  always_comb begin
    temp_n = temp;
    fill_n = fill;
    out_n  = out;
    if (clear) begin
      temp_n = '0;
      fill_n = '0;
      out_n  = 1'b0;
    end else if (valid) begin
      if (restart) begin
        temp_n = {{(WIDTH-1){1'b0}}, data};
        fill_n = ONE;
      end else begin
        temp_n = {temp[WIDTH-2:0], data};
        fill_n = (fill == FULL) ? fill : fill + ONE;
      end
      out_n = (fill_n == FULL) && (temp_n == pattern);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else begin
      temp <= temp_n;
      fill <= fill_n;
      out  <= out_n;
    end
  end

`ifdef PATDET_COUNT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept && out_n && cnt != CMAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt;

  assign unused_cnt = accept;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector (WIDTH=5, CNT_W=2).
// Counter expectations follow PATDET_COUNT_EN.
module tb_pattern_detector;

  localparam int W  = 5;
  localparam int CW = 2;
`ifdef PATDET_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data = 1'b0;
  logic          valid = 1'b0;
  logic          clear = 1'b0;
  logic          overlap = 1'b1;
  logic [W-1:0]  pattern = '0;
  logic          out;
  logic [W-1:0]  temp;
  logic [CW-1:0] match_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pattern_detector #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .valid(valid),
    .clear(clear),
    .overlap(overlap),
    .pattern(pattern),
    .out(out),
    .temp(temp),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ec(input int v);
    return CEN ? 32'(v) : 32'd0;
  endfunction

  task automatic step(input logic d, input logic v, input logic c);
    @(negedge clk);
    data  = d;
    valid = v;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
  endtask

  logic [6:0] s7;
  logic [3:0] s4;

  initial begin
    #2;
    chk("rst_out", 32'(out), 0);
    chk("rst_temp", 32'(temp), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // All-zero pattern: no match until five bits are in.
    pattern = 5'b00000;
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("fill_out_%0d", i), 32'(out), 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("fill_out_full", 32'(out), 1);
    chk("fill_cnt", 32'(match_cnt), ec(1));
    do_clear();
    chk("clr_out", 32'(out), 0);
    chk("clr_cnt", 32'(match_cnt), 0);

    // Overlapping 10101 in 1010101.
    pattern = 5'b10101;
    s7 = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1, 1'b0);
      chk($sformatf("ov_out_%0d", i + 1), 32'(out),
          (i == 4 || i == 6) ? 1 : 0);
    end
    chk("ov_temp", 32'(temp), 32'h15);
    chk("ov_cnt", 32'(match_cnt), ec(2));
    do_clear();

    // Non-overlapping: history restarts after the match.
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1, 1'b0);
      chk($sformatf("nov_out_%0d", i + 1), 32'(out), (i == 4) ? 1 : 0);
      if (i == 5) chk("nov_temp6", 32'(temp), 32'h00);
    end
    chk("nov_temp7", 32'(temp), 32'h01);
    chk("nov_cnt", 32'(match_cnt), ec(1));
    do_clear();

    // Valid gating mid-pattern.
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b0, 1'b0);
      chk($sformatf("gate_temp_%0d", i), 32'(temp), 32'h02);
      chk($sformatf("gate_out_%0d", i), 32'(out), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("gate_out_pre", 32'(out), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("gate_out_hit", 32'(out), 1);
    chk("gate_temp_hit", 32'(temp), 32'h15);
    do_clear();

    // Clear beats valid; the bit is dropped and fill restarts.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    chk("cp_temp", 32'(temp), 0);
    chk("cp_out", 32'(out), 0);
    s4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(s4[3-i], 1'b1, 1'b0);
      chk($sformatf("cp_out_%0d", i + 1), 32'(out), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("cp_out_hit", 32'(out), 1);
    chk("cp_cnt", 32'(match_cnt), ec(1));

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    chk("ar_out", 32'(out), 0);
    chk("ar_temp", 32'(temp), 0);
    chk("ar_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;

    // Counter saturation on ten 1s.
    pattern = 5'b11111;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i >= 4) begin
        chk($sformatf("sat_out_%0d", i + 1), 32'(out), 1);
        chk($sformatf("sat_cnt_%0d", i + 1), 32'(match_cnt),
            ec((i - 3) > 3 ? 3 : (i - 3)));
      end else begin
        chk($sformatf("sat_out_%0d", i + 1), 32'(out), 0);
      end
    end

    // Pattern change with valid low leaves out alone.
    pattern = 5'b00000;
    step(1'b0, 1'b0, 1'b0);
    chk("pchg_out", 32'(out), 1);
    chk("pchg_cnt", 32'(match_cnt), ec(3));
    step(1'b0, 1'b1, 1'b0);
    chk("pchg_next", 32'(out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
